lbdr_param: RTL and testbench

- Parametrised, packet-aware successor of the minimal LBDR router stage. It sits between an input-port flit FIFO and the switch allocator.
- Computes one output port per packet from the header flit using LBDR routing (Rxy) and connectivity (Cx) bits. Adds deroute fallback for unconnected minimal ports and holds the route until the tail flit.
- Drives a pop/grant handshake. Drops unroutable or malformed packets and flags each case with a sticky error.

---
 rtl/lbdr_param.sv | 191 +++++++++++++++++++
 tb/tb_lbdr_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbdr_param.sv
// LBDR routing stage between an input flit FIFO and the switch allocator:
// picks one output port per packet, holds it until the tail, drops bad packets.
module lbdr_param #(
    parameter int unsigned        ADDR_W      = 4,
    parameter logic [2:0]         HDR_ID      = 3'b001,
    parameter logic [2:0]         BODY_ID     = 3'b010,
    parameter logic [2:0]         TAIL_ID     = 3'b100,
    parameter int unsigned        MAX_PKT_LEN = 16,
    parameter logic [7:0]         RXY_RST     = 8'h3C,
    parameter logic [3:0]         CX_RST      = 4'hF,
    parameter logic [ADDR_W-1:0]  CUR_RST     = ADDR_W'(5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [7:0]        cfg_rxy,
    input  logic [3:0]        cfg_cx,
    input  logic [ADDR_W-1:0] cfg_cur,
    input  logic [1:0]        cfg_dr,
    input  logic              empty,
    input  logic [2:0]        flit_id,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              port_grant,
    output logic              flit_pop,
    output logic [4:0]        port_req,
    output logic              deroute,
    output logic              err_unreach,
    output logic              err_proto
);
    localparam int unsigned HALF_W = ADDR_W / 2;
    localparam int unsigned CNT_W  = $clog2(MAX_PKT_LEN + 1);

    // Flit codes must be distinct and the address must split into equal X/Y halves.
    if ((ADDR_W % 2) != 0 || BODY_ID == HDR_ID || BODY_ID == TAIL_ID || HDR_ID == TAIL_ID) begin : g_param_check
        $error("lbdr_param: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_rxy;
    logic [3:0]         r_cx;
    logic [ADDR_W-1:0]  r_cur;
    logic [1:0]         r_dr;
    logic [4:0]         r_port_req;
    logic               r_deroute;
    logic               r_err_unreach;
    logic               r_err_proto;
    logic [CNT_W-1:0]   r_cnt;

    logic [HALF_W-1:0]  w_xc, w_yc, w_xd, w_yd;
    logic               w_n1, w_s1, w_e1, w_w1;
    logic               w_n, w_e, w_w, w_s, w_l;
    logic [4:0]         w_min_sel;
    logic               w_min_any;
    logic [4:0]         w_dr_oh;
    logic               w_dr_ok;
    logic               w_head_hdr;
    logic               w_is_tail;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cnt_full;
    logic               w_pop;
    logic               w_cfg_en;

    assign w_xc = r_cur[HALF_W-1:0];
    assign w_yc = r_cur[ADDR_W-1:HALF_W];
    assign w_xd = dst_addr[HALF_W-1:0];
    assign w_yd = dst_addr[ADDR_W-1:HALF_W];

    assign w_n1 = w_yd < w_yc;
    assign w_s1 = w_yc < w_yd;
    assign w_e1 = w_xc < w_xd;
    assign w_w1 = w_xd < w_xc;

    // Rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, Cx = {Cs,Cw,Ce,Cn}
    assign w_n = ((w_n1 & ~w_e1 & ~w_w1) | (w_n1 & w_e1 & r_rxy[0]) | (w_n1 & w_w1 & r_rxy[1])) & r_cx[0];
    assign w_e = ((w_e1 & ~w_n1 & ~w_s1) | (w_e1 & w_n1 & r_rxy[2]) | (w_e1 & w_s1 & r_rxy[3])) & r_cx[1];
    assign w_w = ((w_w1 & ~w_n1 & ~w_s1) | (w_w1 & w_n1 & r_rxy[4]) | (w_w1 & w_s1 & r_rxy[5])) & r_cx[2];
    assign w_s = ((w_s1 & ~w_e1 & ~w_w1) | (w_s1 & w_e1 & r_rxy[6]) | (w_s1 & w_w1 & r_rxy[7])) & r_cx[3];
    assign w_l = ~w_n1 & ~w_e1 & ~w_w1 & ~w_s1;

    // One-hot {L,S,W,E,N}, priority L>N>E>W>S
    always_comb begin
        w_min_sel = 5'b00000;
        if (w_l)      w_min_sel = 5'b10000;
        else if (w_n) w_min_sel = 5'b00001;
        else if (w_e) w_min_sel = 5'b00010;
        else if (w_w) w_min_sel = 5'b00100;
        else if (w_s) w_min_sel = 5'b01000;
    end

    assign w_min_any  = |w_min_sel;
    assign w_dr_oh    = 5'b00001 << r_dr;
    assign w_dr_ok    = r_cx[r_dr];
    assign w_head_hdr = ~empty & (flit_id == HDR_ID);
    assign w_is_tail  = (flit_id == TAIL_ID);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_cnt_full = (w_cnt_inc == CNT_W'(MAX_PKT_LEN));
    assign w_cfg_en   = cfg_load & empty & (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_head_hdr) w_next_state = (w_min_any || w_dr_ok) ? S_ROUTE : S_DROP;
            S_ROUTE: if (w_pop) begin
                         if (w_is_tail)       w_next_state = S_IDLE;
                         else if (w_cnt_full) w_next_state = S_DROP;
                     end
            S_DROP:  if (w_pop && w_is_tail) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Headers are never popped in IDLE; anything else there is discarded.
    always_comb begin
        w_pop = 1'b0;
        unique case (r_state)
            S_IDLE:  w_pop = ~empty & (flit_id != HDR_ID);
            S_ROUTE: w_pop = ~empty & port_grant;
            S_DROP:  w_pop = ~empty;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxy         <= RXY_RST;
            r_cx          <= CX_RST;
            r_cur         <= CUR_RST;
            r_dr          <= 2'd0;
            r_port_req    <= 5'b00000;
            r_deroute     <= 1'b0;
            r_err_unreach <= 1'b0;
            r_err_proto   <= 1'b0;
            r_cnt         <= '0;
        end else begin
            if (w_cfg_en) begin
                r_rxy <= cfg_rxy;
                r_cx  <= cfg_cx;
                r_cur <= cfg_cur;
                r_dr  <= cfg_dr;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_head_hdr) begin
                        if (w_min_any) begin
                            r_port_req <= w_min_sel;
                        end else if (w_dr_ok) begin
                            r_port_req <= w_dr_oh;
                            r_deroute  <= 1'b1;
                        end else begin
                            r_err_unreach <= 1'b1;
                        end
                    end else if (w_pop) begin
                        r_err_proto <= 1'b1;
                    end
                end
                S_ROUTE: begin
                    if (w_pop) begin
                        if (w_is_tail || w_cnt_full) begin
                            r_port_req <= 5'b00000;
                            r_deroute  <= 1'b0;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                        if (!w_is_tail && w_cnt_full) r_err_proto <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign flit_pop    = w_pop;
    assign port_req    = r_port_req;
    assign deroute     = r_deroute;
    assign err_unreach = r_err_unreach;
    assign err_proto   = r_err_proto;

endmodule

// File: tb/tb_lbdr_param.sv
// Directed bench for lbdr_param: a queue models the input FIFO, expectations
// are hand-derived port codes, pop counts and error flags.
module tb_lbdr_param;
    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;

    typedef struct packed {
        logic [2:0] id;
        logic [3:0] dst;
    } flit_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_rxy = 8'h3C;
    logic [3:0] cfg_cx = 4'hF;
    logic [3:0] cfg_cur = 4'd5;
    logic [1:0] cfg_dr = 2'd0;
    logic       empty = 1'b1;
    logic [2:0] flit_id = 3'b000;
    logic [3:0] dst_addr = 4'd0;
    logic       port_grant = 1'b1;
    logic       flit_pop;
    logic [4:0] port_req;
    logic       deroute;
    logic       err_unreach;
    logic       err_proto;

    flit_t      q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pops  = 0;
    logic [4:0] seen_req = 5'b0;

    lbdr_param dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_rxy    (cfg_rxy),
        .cfg_cx     (cfg_cx),
        .cfg_cur    (cfg_cur),
        .cfg_dr     (cfg_dr),
        .empty      (empty),
        .flit_id    (flit_id),
        .dst_addr   (dst_addr),
        .port_grant (port_grant),
        .flit_pop   (flit_pop),
        .port_req   (port_req),
        .deroute    (deroute),
        .err_unreach(err_unreach),
        .err_proto  (err_proto)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        empty    = (q.size() == 0);
        flit_id  = empty ? 3'b000 : q[0].id;
        dst_addr = empty ? 4'd0 : q[0].dst;
    endtask

    task automatic push(input logic [2:0] id, input logic [3:0] dst);
        flit_t f;
        f.id  = id;
        f.dst = dst;
        q.push_back(f);
        refresh();
    endtask

    task automatic pkt(input logic [3:0] dst, input int nbody);
        push(HDR, dst);
        for (int i = 0; i < nbody; i++) push(BODY, 4'd0);
        push(TAIL, 4'd0);
    endtask

    // One clock: pop decision sampled at negedge, FIFO updated after posedge.
    task automatic step();
        logic pop;
        @(negedge clk);
        pop = flit_pop;
        @(posedge clk);
        #1;
        if (pop) begin
            if (q.size() > 0) q.delete(0);
            n_pops++;
        end
        seen_req |= port_req;
        refresh();
    endtask

    task automatic drain(input string tag, input int max);
        int k = 0;
        while (q.size() != 0 && k < max) begin
            step();
            k++;
        end
        check(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        refresh();
        cfg_load   = 1'b0;
        port_grant = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic load_cfg(input logic [7:0] rxy, input logic [3:0] cx, input logic [3:0] cur, input logic [1:0] dr);
        cfg_rxy  = rxy;
        cfg_cx   = cx;
        cfg_cur  = cur;
        cfg_dr   = dr;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_port_req", 32'(port_req), 32'h00);
        check("rst_deroute", 32'(deroute), 32'd0);
        check("rst_err_unreach", 32'(err_unreach), 32'd0);
        check("rst_err_proto", 32'(err_proto), 32'd0);
        check("rst_flit_pop", 32'(flit_pop), 32'd0);

        // cur=5 (x1,y1), dst=6 (x2,y1) -> East
        pkt(4'd6, 0);
        n_pops = 0;
        step();
        check("east_req", 32'(port_req), 32'h02);
        check("east_no_hdr_pop", 32'(n_pops), 32'd0);
        drain("east_drain", 10);
        check("east_pops", 32'(n_pops), 32'd2);
        check("east_req_clr", 32'(port_req), 32'h00);

        pkt(4'd5, 0);
        step();
        check("local_req", 32'(port_req), 32'h10);
        drain("local_drain", 10);

        // dst=10 (x2,y2): Res=1, Rse=0 -> East
        pkt(4'd10, 1);
        n_pops = 0;
        step();
        check("diag_req", 32'(port_req), 32'h02);
        drain("diag_drain", 10);
        check("diag_pops", 32'(n_pops), 32'd3);

        // East disconnected, deroute South
        load_cfg(8'h3C, 4'b1101, 4'd5, 2'd3);
        pkt(4'd6, 0);
        step();
        check("dr_req", 32'(port_req), 32'h08);
        check("dr_flag", 32'(deroute), 32'd1);
        drain("dr_drain", 10);
        check("dr_flag_clr", 32'(deroute), 32'd0);
        check("dr_no_unreach", 32'(err_unreach), 32'd0);

        // South also disconnected -> unreachable, packet dropped
        load_cfg(8'h3C, 4'b0101, 4'd5, 2'd3);
        pkt(4'd6, 1);
        n_pops   = 0;
        seen_req = 5'b0;
        step();
        check("unr_flag", 32'(err_unreach), 32'd1);
        drain("unr_drain", 10);
        check("unr_pops", 32'(n_pops), 32'd3);
        check("unr_req_never", 32'(seen_req), 32'h00);

        // Grant stall mid-packet
        load_cfg(8'h3C, 4'hF, 4'd5, 2'd0);
        pkt(4'd6, 2);
        n_pops = 0;
        step();
        step();
        port_grant = 1'b0;
        repeat (3) step();
        check("stall_pops", 32'(n_pops), 32'd1);
        check("stall_req_held", 32'(port_req), 32'h02);
        port_grant = 1'b1;
        drain("stall_drain", 10);
        check("stall_total", 32'(n_pops), 32'd4);

        // cfg_load in ROUTE must be ignored
        pkt(4'd6, 0);
        step();
        port_grant = 1'b0;
        cfg_rxy = 8'h00; cfg_cx = 4'h0; cfg_cur = 4'd6; cfg_dr = 2'd1;
        cfg_load = 1'b1;
        step();
        cfg_load   = 1'b0;
        port_grant = 1'b1;
        drain("cfgr_drain", 10);
        pkt(4'd6, 0);
        step();
        check("cfgr_unchanged", 32'(port_req), 32'h02);
        drain("cfgr_drain2", 10);

        // Body flit in IDLE
        do_reset();
        push(BODY, 4'd0);
        step();
        check("idle_body_popped", 32'(q.size()), 32'd0);
        check("idle_body_proto", 32'(err_proto), 32'd1);
        check("idle_body_unreach", 32'(err_unreach), 32'd0);

        // Header + 16 body + tail: overflow on the 16th pop
        do_reset();
        pkt(4'd6, 16);
        n_pops = 0;
        step();
        repeat (15) step();
        check("ovf_before", 32'(err_proto), 32'd0);
        step();
        check("ovf_proto", 32'(err_proto), 32'd1);
        check("ovf_req_clr", 32'(port_req), 32'h00);
        drain("ovf_drain", 10);
        check("ovf_pops", 32'(n_pops), 32'd18);

        // Mid-packet asynchronous reset
        do_reset();
        pkt(4'd6, 3);
        step();
        step();
        step();
        check("mid_req_before", 32'(port_req), 32'h02);
        #2;
        rst = 1'b0;
        #1;
        check("mid_req_async", 32'(port_req), 32'h00);
        rst = 1'b1;
        check("mid_proto_clr", 32'(err_proto), 32'd0);
        n_pops = 0;
        drain("mid_drain", 10);
        check("mid_pops", 32'(n_pops), 32'd3);
        check("mid_proto", 32'(err_proto), 32'd1);
        check("mid_unreach", 32'(err_unreach), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
